// File: rtl/p32_fwd_pkg.sv
// Shared defaults, stage indices and the destination-tag entry for the p32 forwarding unit.
// Tag dst is held at a fixed maximum width so the struct stays usable for any ADDR_W up to it.
package p32_fwd_pkg;

   localparam int P32_DATA_W     = 32;
   localparam int P32_ADDR_W     = 5;
   localparam int P32_NREAD      = 2;
   localparam int P32_NSTAGE     = 3;
   localparam int P32_LOAD_READY = 1;
   localparam int P32_CNT_W      = 16;

   localparam int STG_EX  = 0;
   localparam int STG_MEM = 1;
   localparam int STG_WB  = 2;

   localparam int TAG_ADDR_W = 8;

   typedef struct packed {
      logic                  v;
      logic [TAG_ADDR_W-1:0] dst;
      logic                  ld;
   } tag_t;

endpackage

// File: rtl/p32_fwd_port.sv
// One operand port: youngest-match priority select across the tag pipeline,
// operand mux and load-use hazard flag.
module p32_fwd_port
   import p32_fwd_pkg::*;
#(
   parameter int DATA_W     = P32_DATA_W,
   parameter int ADDR_W     = P32_ADDR_W,
   parameter int NSTAGE     = P32_NSTAGE,
   parameter int LOAD_READY = P32_LOAD_READY
)(
   input  logic                         i_rd_en,
   input  logic [ADDR_W-1:0]            i_rd_addr,
   input  logic [DATA_W-1:0]            i_rd_in,
   input  logic [NSTAGE*DATA_W-1:0]     i_stage_data,
   input  logic [NSTAGE-1:0]            i_tag_v,
   input  logic [NSTAGE-1:0]            i_tag_ld,
   input  logic [NSTAGE*TAG_ADDR_W-1:0] i_tag_dst,
   output logic [DATA_W-1:0]            o_rd_out,
   output logic                         o_hazard
);

   logic [TAG_ADDR_W-1:0] w_addr_ext;
   logic                  w_hit;
   logic                  w_hit_ld;
   logic                  w_hit_early;
   logic [DATA_W-1:0]     w_fwd;

   always_comb begin
      w_addr_ext = '0;
      w_addr_ext[ADDR_W-1:0] = i_rd_addr;
   end

   // Scan oldest to youngest so the youngest matching stage is the last to overwrite.
   always_comb begin
      w_hit       = 1'b0;
      w_hit_ld    = 1'b0;
      w_hit_early = 1'b0;
      w_fwd       = i_rd_in;
      for (int s = NSTAGE - 1; s >= 0; s--) begin
         if (i_tag_v[s] && (i_tag_dst[s*TAG_ADDR_W +: TAG_ADDR_W] == w_addr_ext)) begin
            w_hit       = 1'b1;
            w_hit_ld    = i_tag_ld[s];
            w_hit_early = (s < LOAD_READY);
            w_fwd       = i_stage_data[s*DATA_W +: DATA_W];
         end
      end
   end

   assign o_rd_out = (i_rd_addr == '0) ? '0 : w_fwd;
   assign o_hazard = i_rd_en & w_hit & w_hit_ld & w_hit_early & (i_rd_addr != '0);

endmodule

// File: rtl/p32_fwd_scoreboard.sv
// Forwarding/bypass unit: owns the EX..WB destination-tag pipeline, forwards to NREAD
// operand ports and raises the decode stall on load-use hazards, counting stall cycles.
module p32_fwd_scoreboard
   import p32_fwd_pkg::*;
#(
   parameter int DATA_W     = P32_DATA_W,
   parameter int ADDR_W     = P32_ADDR_W,
   parameter int NREAD      = P32_NREAD,
   parameter int NSTAGE     = P32_NSTAGE,
   parameter int LOAD_READY = P32_LOAD_READY,
   parameter int CNT_W      = P32_CNT_W
)(
   input  logic                     m_clock,
   input  logic                     p_reset,
   input  logic                     id_valid,
   input  logic                     id_we,
   input  logic                     id_load,
   input  logic [ADDR_W-1:0]        id_dst,
   input  logic                     flush,
   input  logic [NREAD-1:0]         rd_en,
   input  logic [NREAD*ADDR_W-1:0]  rd_addr,
   input  logic [NREAD*DATA_W-1:0]  rd_in,
   input  logic [NSTAGE*DATA_W-1:0] stage_data,
   output logic [NREAD*DATA_W-1:0]  rd_out,
   output logic                     stall_out,
   output logic [CNT_W-1:0]         stall_count
);

   tag_t                         r_tag [NSTAGE];
   logic [CNT_W-1:0]             r_stall_count;
   tag_t                         w_tag_in;
   logic                         w_accept;
   logic [NREAD-1:0]             w_hazard;
   logic [NSTAGE-1:0]            w_tag_v;
   logic [NSTAGE-1:0]            w_tag_ld;
   logic [NSTAGE*TAG_ADDR_W-1:0] w_tag_dst;

   // Flush beats stall: a flushed decode slot never stalls and never enters EX.
   assign stall_out = id_valid & ~flush & (|w_hazard);
   assign w_accept  = id_valid & id_we & (id_dst != '0) & ~stall_out & ~flush;

   always_comb begin
      w_tag_in = '0;
      if (w_accept) begin
         w_tag_in.v                = 1'b1;
         w_tag_in.dst[ADDR_W-1:0]  = id_dst;
         w_tag_in.ld               = id_load;
      end
   end

   always_ff @(posedge m_clock or negedge p_reset) begin
      if (!p_reset) begin
         for (int s = 0; s < NSTAGE; s++) begin
            r_tag[s] <= '0;
         end
      end else begin
         r_tag[0] <= w_tag_in;
         for (int s = 1; s < NSTAGE; s++) begin
            r_tag[s] <= r_tag[s-1];
         end
      end
   end

   always_ff @(posedge m_clock or negedge p_reset) begin
      if (!p_reset) begin
         r_stall_count <= '0;
      end else if (stall_out && (r_stall_count != '1)) begin
         r_stall_count <= r_stall_count + 1'b1;
      end
   end

   assign stall_count = r_stall_count;

   genvar gi;
   generate
      for (gi = 0; gi < NSTAGE; gi++) begin : g_tag_flat
         assign w_tag_v[gi]                               = r_tag[gi].v;
         assign w_tag_ld[gi]                              = r_tag[gi].ld;
         assign w_tag_dst[gi*TAG_ADDR_W +: TAG_ADDR_W]    = r_tag[gi].dst;
      end

      for (gi = 0; gi < NREAD; gi++) begin : g_port
         p32_fwd_port #(
            .DATA_W     (DATA_W),
            .ADDR_W     (ADDR_W),
            .NSTAGE     (NSTAGE),
            .LOAD_READY (LOAD_READY)
         ) u_port (
            .i_rd_en      (rd_en[gi]),
            .i_rd_addr    (rd_addr[gi*ADDR_W +: ADDR_W]),
            .i_rd_in      (rd_in[gi*DATA_W +: DATA_W]),
            .i_stage_data (stage_data),
            .i_tag_v      (w_tag_v),
            .i_tag_ld     (w_tag_ld),
            .i_tag_dst    (w_tag_dst),
            .o_rd_out     (rd_out[gi*DATA_W +: DATA_W]),
            .o_hazard     (w_hazard[gi])
         );
      end
   endgenerate

endmodule

// File: tb/tb_p32_fwd_scoreboard.sv
// Bench for p32_fwd_scoreboard: a default instance plus one with LOAD_READY=2, CNT_W=4,
// both driven from the same stimulus; expectations queued per cycle and drained on settle.
module tb_p32_fwd_scoreboard;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 2;
   localparam int NS = 3;

   logic              clk;
   logic              p_reset;
   logic              id_valid;
   logic              id_we;
   logic              id_load;
   logic [AW-1:0]     id_dst;
   logic              flush;
   logic [NR-1:0]     rd_en;
   logic [NR*AW-1:0]  rd_addr;
   logic [NR*DW-1:0]  rd_in;
   logic [NS*DW-1:0]  stage_data;
   logic [NR*DW-1:0]  rd_out;
   logic              stall_out;
   logic [15:0]       stall_count;
   logic [NR*DW-1:0]  rd_out2;
   logic              stall2;
   logic [3:0]        count2;

   typedef struct {
      string       tag;
      int          sig;
      logic [31:0] val;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   p32_fwd_scoreboard u_dut (
      .m_clock     (clk),
      .p_reset     (p_reset),
      .id_valid    (id_valid),
      .id_we       (id_we),
      .id_load     (id_load),
      .id_dst      (id_dst),
      .flush       (flush),
      .rd_en       (rd_en),
      .rd_addr     (rd_addr),
      .rd_in       (rd_in),
      .stage_data  (stage_data),
      .rd_out      (rd_out),
      .stall_out   (stall_out),
      .stall_count (stall_count)
   );

   p32_fwd_scoreboard #(.LOAD_READY(2), .CNT_W(4)) u_dut2 (
      .m_clock     (clk),
      .p_reset     (p_reset),
      .id_valid    (id_valid),
      .id_we       (id_we),
      .id_load     (id_load),
      .id_dst      (id_dst),
      .flush       (flush),
      .rd_en       (rd_en),
      .rd_addr     (rd_addr),
      .rd_in       (rd_in),
      .stage_data  (stage_data),
      .rd_out      (rd_out2),
      .stall_out   (stall2),
      .stall_count (count2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1);
   end

   function automatic logic [31:0] get_obs(input int sig);
      case (sig)
         0:       return rd_out[31:0];
         1:       return rd_out[63:32];
         2:       return {31'd0, stall_out};
         3:       return {16'd0, stall_count};
         4:       return {31'd0, stall2};
         5:       return {28'd0, count2};
         6:       return rd_out2[31:0];
         default: return rd_out2[63:32];
      endcase
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got 0x%0h required 0x%0h", tag, obs, exp_v);
      end else begin
         $display("ok   %s: 0x%0h", tag, obs);
      end
   endtask

   task automatic expect_val(input string tag, input int sig, input logic [31:0] val);
      exp_t e;
      e.tag = tag;
      e.sig = sig;
      e.val = val;
      sb_q.push_back(e);
   endtask

   task automatic drain();
      exp_t e;
      #2;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check_eq(e.tag, get_obs(e.sig), e.val);
      end
   endtask

   task automatic drive(input logic v, input logic we, input logic ld, input logic [AW-1:0] dst,
                        input logic fl, input logic en0, input logic [AW-1:0] a0,
                        input logic [AW-1:0] a1);
      @(negedge clk);
      id_valid = v;
      id_we    = we;
      id_load  = ld;
      id_dst   = dst;
      flush    = fl;
      rd_en    = {1'b0, en0};
      rd_addr  = {a1, a0};
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
      drain();
   endtask

   initial begin
      p_reset    = 1'b0;
      id_valid   = 1'b0;
      id_we      = 1'b0;
      id_load    = 1'b0;
      id_dst     = '0;
      flush      = 1'b0;
      rd_en      = '0;
      rd_addr    = '0;
      rd_in      = {32'h22, 32'h11};
      stage_data = {32'hCC, 32'hBB, 32'hAA};

      // Reset state
      drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd3, 5'd0);
      expect_val("rst_rd0", 0, 32'h11);
      expect_val("rst_stall", 2, 32'd0);
      expect_val("rst_cnt", 3, 32'd0);
      expect_val("rst_cnt2", 5, 32'd0);
      drain();
      p_reset = 1'b1;

      // ALU r5 ages EX -> MEM -> WB -> retired
      drive(1'b1, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 5'd3, 5'd0);
      expect_val("alu_acc_rd0", 0, 32'h11);
      drain();
      drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 5'd0);
      expect_val("fwd_ex", 0, 32'hAA);
      expect_val("fwd_ex_d2", 6, 32'hAA);
      drain();
      drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 5'd0);
      expect_val("fwd_mem", 0, 32'hBB);
      drain();
      drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 5'd0);
      expect_val("fwd_wb", 0, 32'hCC);
      drain();
      drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 5'd0);
      expect_val("fwd_retired", 0, 32'h11);
      drain();

      // r7 written twice: youngest wins; r0 write attempt and addr 0 read
      drive(1'b1, 1'b1, 1'b0, 5'd7, 1'b0, 1'b0, 5'd3, 5'd0);
      expect_val("r7a_acc", 0, 32'h11);
      drain();
      drive(1'b1, 1'b1, 1'b0, 5'd7, 1'b0, 1'b1, 5'd7, 5'd0);
      expect_val("r7_one", 0, 32'hAA);
      drain();
      drive(1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 5'd0);
      expect_val("r7_youngest", 0, 32'hAA);
      expect_val("addr0_rd1", 1, 32'h0);
      expect_val("addr0_rd1_d2", 7, 32'h0);
      drain();
      drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 5'd0);
      expect_val("r7_mem", 0, 32'hBB);
      drain();
      drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 5'd0);
      expect_val("r7_wb", 0, 32'hCC);
      drain();
      drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 5'd0);
      expect_val("r7_gone", 0, 32'h11);
      drain();

      // Load r4 then consumer: 1 stall on default, 2 on LOAD_READY=2
      drive(1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 5'd3, 5'd0);
      expect_val("ld_acc_stall", 2, 32'd0);
      drain();
      drive(1'b1, 1'b1, 1'b0, 5'd9, 1'b0, 1'b1, 5'd4, 5'd0);
      expect_val("lu_stall_c1", 2, 32'd1);
      expect_val("lu_stall2_c1", 4, 32'd1);
      expect_val("lu_rd0_c1", 0, 32'hAA);
      drain();
      drive(1'b1, 1'b1, 1'b0, 5'd9, 1'b0, 1'b1, 5'd4, 5'd0);
      expect_val("lu_stall_c2", 2, 32'd0);
      expect_val("lu_stall2_c2", 4, 32'd1);
      expect_val("lu_rd0_mem", 0, 32'hBB);
      expect_val("lu_cnt_c2", 3, 32'd1);
      drain();
      drive(1'b1, 1'b1, 1'b0, 5'd9, 1'b0, 1'b1, 5'd4, 5'd0);
      expect_val("lu_stall2_c3", 4, 32'd0);
      expect_val("lu_rd0_d2_wb", 6, 32'hCC);
      expect_val("lu_cnt", 3, 32'd1);
      expect_val("lu_cnt2", 5, 32'd2);
      drain();
      idle();
      idle();
      idle();

      // Flush during a hazard: no stall, no entry inserted
      drive(1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 5'd3, 5'd0);
      drain();
      drive(1'b1, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 5'd4, 5'd0);
      expect_val("fl_stall", 2, 32'd0);
      expect_val("fl_stall2", 4, 32'd0);
      drain();
      drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd9, 5'd4);
      expect_val("fl_no_entry", 0, 32'h11);
      expect_val("fl_old_kept", 1, 32'hBB);
      expect_val("fl_cnt", 3, 32'd1);
      drain();
      idle();
      idle();

      // Asynchronous reset in the middle of a stall
      drive(1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 5'd3, 5'd0);
      drain();
      drive(1'b1, 1'b1, 1'b0, 5'd9, 1'b0, 1'b1, 5'd4, 5'd0);
      expect_val("mr_stall_pre", 2, 32'd1);
      drain();
      p_reset = 1'b0;
      expect_val("mr_stall", 2, 32'd0);
      expect_val("mr_stall2", 4, 32'd0);
      expect_val("mr_rd0", 0, 32'h11);
      expect_val("mr_rd1", 1, 32'h0);
      expect_val("mr_cnt", 3, 32'd0);
      expect_val("mr_cnt2", 5, 32'd0);
      drain();
      @(negedge clk);
      p_reset = 1'b1;

      // Repeated load-use pairs: counter2 (4 bits) saturates at 15
      for (int i = 1; i <= 10; i++) begin
         drive(1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 5'd3, 5'd0);
         expect_val($sformatf("sat_cnt_%0d", i), 3, 32'(i - 1));
         expect_val($sformatf("sat_cnt2_%0d", i), 5, (2 * (i - 1) > 15) ? 32'd15 : 32'(2 * (i - 1)));
         drain();
         drive(1'b1, 1'b1, 1'b0, 5'd9, 1'b0, 1'b1, 5'd4, 5'd0);
         expect_val($sformatf("sat_stall_%0d", i), 2, 32'd1);
         drain();
         drive(1'b1, 1'b1, 1'b0, 5'd9, 1'b0, 1'b1, 5'd4, 5'd0);
         expect_val($sformatf("sat_stall2_%0d", i), 4, 32'd1);
         drain();
      end
      drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
      expect_val("sat_final_cnt", 3, 32'd10);
      expect_val("sat_final_cnt2", 5, 32'd15);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
